// File: rtl/vgpr_2to1_wr_port_arbiter_pkg.sv
// rtl/vgpr_2to1_wr_port_arbiter_pkg.sv - shared VGPR write/read port constants and grant helper
package vgpr_2to1_wr_port_arbiter_pkg;

  localparam int VGPR_ADDR_WIDTH = 10;
  localparam int VGPR_DATAWIDTH  = 2048;
  localparam int VGPR_MASKWIDTH  = 64;
  localparam int VGPR_FIFO_DEPTH = 2;

  typedef enum logic {
    GRANT_P0 = 1'b0,
    GRANT_P1 = 1'b1
  } grant_e;

  // Round-robin choice; only meaningful when at least one port is non-empty.
  function automatic grant_e rr_pick(input logic ne0, input logic ne1, input grant_e last);
    if (ne0 && ne1) return (last == GRANT_P0) ? GRANT_P1 : GRANT_P0;
    if (ne1) return GRANT_P1;
    return GRANT_P0;
  endfunction

endpackage

// File: rtl/vgpr_wr_fifo.sv
// rtl/vgpr_wr_fifo.sv - small per-port write buffer with registered count and head output
module vgpr_wr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic [WIDTH-1:0]             head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH-1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/vgpr_2to1_wr_port_arbiter.sv
// rtl/vgpr_2to1_wr_port_arbiter.sv - merges two buffered VGPR write ports onto one registered write port
module vgpr_2to1_wr_port_arbiter
  import vgpr_2to1_wr_port_arbiter_pkg::*;
#(
  parameter int DATAWIDTH  = VGPR_DATAWIDTH,
  parameter int MASKWIDTH  = VGPR_MASKWIDTH,
  parameter int FIFO_DEPTH = VGPR_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       port0_wr_en,
  input  logic [VGPR_ADDR_WIDTH-1:0] port0_wr_addr,
  input  logic [DATAWIDTH-1:0]       port0_wr_data,
  input  logic [MASKWIDTH-1:0]       port0_wr_mask,
  output logic                       port0_wr_ready,
  input  logic                       port1_wr_en,
  input  logic [VGPR_ADDR_WIDTH-1:0] port1_wr_addr,
  input  logic [DATAWIDTH-1:0]       port1_wr_data,
  input  logic [MASKWIDTH-1:0]       port1_wr_mask,
  output logic                       port1_wr_ready,
  output logic                       wr_en,
  output logic [VGPR_ADDR_WIDTH-1:0] wr_addr,
  output logic [DATAWIDTH-1:0]       wr_data,
  output logic [MASKWIDTH-1:0]       wr_mask,
  output logic                       wr_overflow
);

  localparam int AW    = VGPR_ADDR_WIDTH;
  localparam int EW    = AW + DATAWIDTH + MASKWIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [EW-1:0]    head0, head1, head_sel;
  logic [CNT_W-1:0] cnt0, cnt1;
  logic             push0, push1, pop0, pop1, ne0, ne1;
  grant_e           sel, last_q, last_d;

  logic           wr_en_q, wr_en_d, ovf_q, ovf_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [DATAWIDTH-1:0] wr_data_q, wr_data_d;
  logic [MASKWIDTH-1:0] wr_mask_q, wr_mask_d;

  vgpr_wr_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(clk), .rst_n(rst_n), .push_i(push0), .pop_i(pop0),
    .data_i({port0_wr_addr, port0_wr_data, port0_wr_mask}),
    .head_o(head0), .count_o(cnt0)
  );

  vgpr_wr_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .push_i(push1), .pop_i(pop1),
    .data_i({port1_wr_addr, port1_wr_data, port1_wr_mask}),
    .head_o(head1), .count_o(cnt1)
  );

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
  assign port0_wr_ready = (cnt0 < DEPTH_C);
  assign port1_wr_ready = (cnt1 < DEPTH_C);
  assign push0 = port0_wr_en & port0_wr_ready;
  assign push1 = port1_wr_en & port1_wr_ready;
  assign ne0   = (cnt0 != '0);
  assign ne1   = (cnt1 != '0);

  always_comb begin
    sel       = rr_pick(ne0, ne1, last_q);
    pop0      = ne0 && (sel == GRANT_P0);
    pop1      = ne1 && (sel == GRANT_P1);
    head_sel  = (sel == GRANT_P1) ? head1 : head0;
    last_d    = last_q;
    wr_en_d   = pop0 | pop1;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_mask_d = wr_mask_q;
    if (wr_en_d) begin
      last_d = sel;
      {wr_addr_d, wr_data_d, wr_mask_d} = head_sel;
    end
    ovf_d = ovf_q | (port0_wr_en & ~port0_wr_ready) | (port1_wr_en & ~port1_wr_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= GRANT_P1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_mask_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_mask_q <= wr_mask_d;
      ovf_q     <= ovf_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_mask     = wr_mask_q;
  assign wr_overflow = ovf_q;

endmodule

// File: tb/tb_vgpr_2to1_wr_port_arbiter.sv
// tb/tb_vgpr_2to1_wr_port_arbiter.sv - self-checking bench for the two-to-one VGPR write arbiter
module tb_vgpr_2to1_wr_port_arbiter;
  import vgpr_2to1_wr_port_arbiter_pkg::*;

  localparam int AW = VGPR_ADDR_WIDTH;
  localparam int DW = VGPR_DATAWIDTH;
  localparam int MW = VGPR_MASKWIDTH;
  localparam int D  = VGPR_FIFO_DEPTH;

  logic clk, rst_n;
  logic          p0_en, p1_en, p0_rdy, p1_rdy;
  logic [AW-1:0] p0_addr, p1_addr, o_addr;
  logic [DW-1:0] p0_data, p1_data, o_data;
  logic [MW-1:0] p0_mask, p1_mask, o_mask;
  logic          o_en, o_ovf;

  vgpr_2to1_wr_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .port0_wr_en(p0_en), .port0_wr_addr(p0_addr), .port0_wr_data(p0_data),
    .port0_wr_mask(p0_mask), .port0_wr_ready(p0_rdy),
    .port1_wr_en(p1_en), .port1_wr_addr(p1_addr), .port1_wr_data(p1_data),
    .port1_wr_mask(p1_mask), .port1_wr_ready(p1_rdy),
    .wr_en(o_en), .wr_addr(o_addr), .wr_data(o_data), .wr_mask(o_mask),
    .wr_overflow(o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
  } ent_t;

  typedef struct {
    bit            e0, e1;
    logic [AW-1:0] a0, a1;
    bit            r0, r1, oen;
    logic [AW-1:0] oaddr;
  } vec_t;

  // Reference model: per-port queues, last-granted port, sticky overflow, output register.
  ent_t q0[$], q1[$];
  int   last_p;
  bit   m_en, m_ovf;
  ent_t m_out;

  int n_cmp, n_bad;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got ...%h want ...%h (low 64 bits)", nm, act[63:0], exp[63:0]);
    end
  endtask

  function automatic ent_t mk(input int port, input logic [AW-1:0] a);
    ent_t e;
    logic pb;
    pb     = port[0];
    e.addr = a;
    e.data = {64{pb, 5'h15, a, 16'hC3A5}};
    e.mask = {54'h0, a} ^ 64'hF0F0_F0F0_F0F0_F0F0;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.addr = AW'($urandom_range(0, 1023));
    for (int w = 0; w < DW/32; w++) e.data[w*32 +: 32] = $urandom();
    e.mask = {$urandom(), $urandom()};
    if ($urandom_range(0, 7) == 0) e.mask = '0;
    return e;
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    last_p = 1;
    m_en   = 1'b0;
    m_ovf  = 1'b0;
    m_out  = '{addr: '0, data: '0, mask: '0};
  endtask

  task automatic model_edge(input bit e0, input ent_t x0, input bit e1, input ent_t x1);
    bit ok0, ok1;
    ok0 = e0 && (q0.size() < D);
    ok1 = e1 && (q1.size() < D);
    if (e0 && !ok0) m_ovf = 1'b1;
    if (e1 && !ok1) m_ovf = 1'b1;
    m_en = 1'b1;
    if (q0.size() > 0 && (q1.size() == 0 || last_p == 1)) begin
      m_out = q0.pop_front();
      last_p = 0;
    end else if (q1.size() > 0) begin
      m_out = q1.pop_front();
      last_p = 1;
    end else begin
      m_en = 1'b0;
    end
    if (ok0) q0.push_back(x0);
    if (ok1) q1.push_back(x1);
  endtask

  // Called just after a falling edge; returns the ready values seen before the rising edge.
  task automatic step(input bit e0, input ent_t x0, input bit e1, input ent_t x1,
                      output logic r0, output logic r1);
    p0_en = e0; p0_addr = x0.addr; p0_data = x0.data; p0_mask = x0.mask;
    p1_en = e1; p1_addr = x1.addr; p1_data = x1.data; p1_mask = x1.mask;
    #1;
    r0 = p0_rdy;
    r1 = p1_rdy;
    chk("ready0", r0, 64'(q0.size() < D));
    chk("ready1", r1, 64'(q1.size() < D));
    @(posedge clk);
    model_edge(e0, x0, e1, x1);
    #1;
    chk("wr_en", o_en, 64'(m_en));
    chk("wr_overflow", o_ovf, 64'(m_ovf));
    chk("wr_addr", o_addr, 64'(m_out.addr));
    chk("wr_mask", o_mask, m_out.mask);
    chk_data("wr_data", o_data, m_out.data);
    @(negedge clk);
    p0_en = 1'b0;
    p1_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    p0_en = 1'b0;
    p1_en = 1'b0;
    #1;
    model_reset();
    chk("rst_wr_en", o_en, 0);
    chk("rst_ready0", p0_rdy, 1);
    chk("rst_ready1", p1_rdy, 1);
    chk("rst_wr_addr", o_addr, 0);
    chk("rst_wr_mask", o_mask, 0);
    chk_data("rst_wr_data", o_data, '0);
    chk("rst_overflow", o_ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[12];
  ent_t idle, x, y;
  logic r0, r1;
  bit   seen;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    p0_en = 1'b0; p1_en = 1'b0;
    p0_addr = '0; p1_addr = '0; p0_data = '0; p1_data = '0; p0_mask = '0; p1_mask = '0;
    idle = '{addr: '0, data: '0, mask: '0};

    // Both writers pushing whenever ready, then draining.
    tbl[0]  = '{1'b1, 1'b1, 10'h010, 10'h100, 1'b1, 1'b1, 1'b0, 10'h000};
    tbl[1]  = '{1'b1, 1'b1, 10'h011, 10'h101, 1'b1, 1'b1, 1'b1, 10'h010};
    tbl[2]  = '{1'b1, 1'b0, 10'h012, 10'h000, 1'b1, 1'b0, 1'b1, 10'h100};
    tbl[3]  = '{1'b0, 1'b1, 10'h000, 10'h102, 1'b0, 1'b1, 1'b1, 10'h011};
    tbl[4]  = '{1'b1, 1'b0, 10'h013, 10'h000, 1'b1, 1'b0, 1'b1, 10'h101};
    tbl[5]  = '{1'b0, 1'b1, 10'h000, 10'h103, 1'b0, 1'b1, 1'b1, 10'h012};
    tbl[6]  = '{1'b1, 1'b0, 10'h014, 10'h000, 1'b1, 1'b0, 1'b1, 10'h102};
    tbl[7]  = '{1'b0, 1'b1, 10'h000, 10'h104, 1'b0, 1'b1, 1'b1, 10'h013};
    tbl[8]  = '{1'b0, 1'b0, 10'h000, 10'h000, 1'b1, 1'b0, 1'b1, 10'h103};
    tbl[9]  = '{1'b0, 1'b0, 10'h000, 10'h000, 1'b1, 1'b1, 1'b1, 10'h014};
    tbl[10] = '{1'b0, 1'b0, 10'h000, 10'h000, 1'b1, 1'b1, 1'b1, 10'h104};
    tbl[11] = '{1'b0, 1'b0, 10'h000, 10'h000, 1'b1, 1'b1, 1'b0, 10'h104};

    // Single port0 write with A5 data, two-cycle latency.
    do_reset();
    x.addr = 10'h005;
    x.data = {256{8'hA5}};
    x.mask = '1;
    step(1'b1, x, 1'b0, idle, r0, r1);
    chk("single_lat1_en", o_en, 0);
    step(1'b0, idle, 1'b0, idle, r0, r1);
    chk("single_en", o_en, 1);
    chk("single_addr", o_addr, 64'h005);
    chk("single_mask", o_mask, '1);
    chk_data("single_data", o_data, {256{8'hA5}});
    step(1'b0, idle, 1'b0, idle, r0, r1);
    chk("single_after_en", o_en, 0);
    chk("single_hold_addr", o_addr, 64'h005);

    // Table of alternating saturation.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].e0, mk(0, tbl[i].a0), tbl[i].e1, mk(1, tbl[i].a1), r0, r1);
      chk("tbl_ready0", r0, 64'(tbl[i].r0));
      chk("tbl_ready1", r1, 64'(tbl[i].r1));
      chk("tbl_wr_en", o_en, 64'(tbl[i].oen));
      chk("tbl_wr_addr", o_addr, 64'(tbl[i].oaddr));
      if (tbl[i].oen) chk_data("tbl_wr_data", o_data, mk(int'(tbl[i].oaddr[8]), tbl[i].oaddr).data);
      chk("tbl_overflow", o_ovf, 0);
    end

    // port1 back-to-back while port0 saturates; third port1 write is forced and dropped.
    do_reset();
    step(1'b1, mk(0, 10'h020), 1'b1, mk(1, 10'h200), r0, r1);
    step(1'b1, mk(0, 10'h021), 1'b1, mk(1, 10'h201), r0, r1);
    step(1'b1, mk(0, 10'h022), 1'b1, mk(1, 10'h202), r0, r1);
    chk("p1_ready_3rd", r1, 0);
    chk("ovf_after_forced", o_ovf, 1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, idle, 1'b0, idle, r0, r1);
      if (o_en && o_addr == 10'h202) seen = 1'b1;
    end
    chk("dropped_write_absent", 64'(seen), 0);
    chk("ovf_sticky", o_ovf, 1);

    // Same address on both ports in one cycle.
    do_reset();
    x = mk(0, 10'h03F);
    y = mk(1, 10'h03F);
    step(1'b1, x, 1'b1, y, r0, r1);
    step(1'b0, idle, 1'b0, idle, r0, r1);
    chk("same_addr_first", o_addr, 64'h03F);
    chk_data("same_addr_p0_first", o_data, x.data);
    step(1'b0, idle, 1'b0, idle, r0, r1);
    chk("same_addr_second_en", o_en, 1);
    chk_data("same_addr_p1_second", o_data, y.data);

    // Reset with writes in flight.
    do_reset();
    step(1'b1, mk(0, 10'h030), 1'b1, mk(1, 10'h130), r0, r1);
    step(1'b1, mk(0, 10'h031), 1'b1, mk(1, 10'h131), r0, r1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, idle, 1'b0, idle, r0, r1);
      chk("post_reset_no_write", o_en, 0);
    end

    // Randomized traffic against the model, mostly honouring ready.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit e0, e1;
      e0 = ($urandom_range(0, 3) != 0);
      e1 = ($urandom_range(0, 3) != 0);
      if (q0.size() >= D && $urandom_range(0, 15) != 0) e0 = 1'b0;
      if (q1.size() >= D && $urandom_range(0, 15) != 0) e1 = 1'b0;
      step(e0, rnd_ent(), e1, rnd_ent(), r0, r1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
